regfile_dump_rx: RTL and testbench
==================================

# regfile_dump_rx

Host-side receiver for the processor's register-file dump stream. The block deserialises 8N1 UART bytes at a fixed bit period and reassembles each 128-byte frame into 32 little-endian 32-bit words. It emits each word with a one-cycle strobe and also keeps a readable shadow copy of the register file. It sits at the far end of the serial link from the regfile dump transmitter and lets a bench or FPGA host check processor state after every executed instruction.

## Interface
- CLKS_PER_BIT, 104: clk12 cycles per UART bit (12 MHz / 115200).
- TIMEOUT_CLKS, 2080: idle clk12 cycles allowed between bytes inside a frame before the frame is aborted.
- clk12  in  1  system clock; the block's only clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial input, idles high.
- word_valid  out  1  one-cycle strobe: word_data/word_index hold a completed word.
- word_index  out  5  register number of the current word, 0..31.
- word_data  out  32  assembled word; the first-received byte is bits [7:0].
- frame_done  out  1  one-cycle strobe: word 31 completed.
- frame_error  out  1  one-cycle strobe: bad stop bit or inter-byte timeout; partial frame discarded.
- busy  out  1  high while a frame is in progress (at least one byte of the frame received).
- shadow_read_address  in  5  shadow register-file read address.
- shadow_read_data  out  32  combinational read of the shadow entry.

## Operation
- Bit FSM states and transitions:
  - IDLE -> START on a falling edge of rx.
  - START: wait CLKS_PER_BIT/2 (integer division), then sample rx. If low -> DATA. If high -> IDLE (glitch, no error).
  - DATA: 8 samples, one every CLKS_PER_BIT, LSB first. Then -> STOP.
  - STOP: one sample after CLKS_PER_BIT. If high, the byte is accepted. If low, frame_error is raised. Either way -> IDLE in the same cycle, i.e. mid stop bit, so back-to-back bytes are caught.
- Frame assembly:
  - byte_index (2 b) and word_index (5 b) count from 0.
  - An accepted byte is written to word bits [8*byte_index+7 : 8*byte_index], then byte_index increments.
  - When byte_index wraps 3 -> 0, the block pulses word_valid, writes shadow[word_index], and increments word_index.
  - After word 31, both counters return to 0, frame_done pulses with that word's word_valid, and busy drops.
- Shadow register file: 32×32 bits, all entries written as received, register 0 included. Entries are never cleared except by rst.
- Timeout: the counter runs only while busy and the bit FSM is in IDLE, and clears on every start-edge detect. When it reaches TIMEOUT_CLKS, frame_error pulses, both counters clear, and busy drops.
- Error handling: after any frame_error the next accepted byte is treated as byte 0 of word 0. No word_valid is issued for a partial word.

## Timing
- Reset values:
  - word_valid, frame_done, frame_error, busy: 0.
  - word_index: 0; word_data: 0.
  - All shadow entries: 0.
  - FSM in IDLE with all counters at 0.
- Reset asserted mid-byte or mid-frame aborts at once, with no strobe.
- All outputs except shadow_read_data are registered.
- Latency, with E = clk12 cycle in which the start edge reaches the pin and S = synchroniser depth (2 with REGFILE_RX_SYNC_EN, 0 without):
  - Stop sample at E + S + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - word_valid / frame_error one cycle later.
- The shadow write is visible on shadow_read_data the cycle after word_valid.
- Simultaneous events:
  - frame_done always coincides with word_valid for index 31.
  - frame_error and word_valid are never asserted together.
  - A timeout and a start edge in the same cycle: the start edge wins and there is no error.
- No backpressure: the consumer must take word_data in the word_valid cycle. word_data holds until the next word_valid.

## Configuration
- REGFILE_RX_SYNC_EN defined: rx passes through a two-flop synchroniser to clk12 before edge detection (S = 2). Use this when rx comes from an asynchronous pin.
- REGFILE_RX_SYNC_EN undefined: rx is sampled directly (S = 0), for simulation or when rx is already synchronous to clk12. No other behaviour changes.

## Test plan
All scenarios use CLKS_PER_BIT=4, TIMEOUT_CLKS=80.
- Full frame, word i = 32'hA5000000 | i, bytes sent LSB first and back-to-back -> 32 word_valid pulses with index 0..31 and matching data; frame_done only with index 31; shadow[7] reads 32'hA5000007.
- Byte with stop bit driven low, in the middle of word 3 -> frame_error pulses once, busy drops. A following fresh frame yields word_index 0 first.
- 5 bytes sent, then rx held high for 100 cycles -> frame_error when the idle count reaches 80. No word_valid for the partial word 1. Word 0 stays in shadow[0].
- 1-cycle low glitch on idle rx -> no strobe, busy stays 0, the next real byte decodes correctly.
- rst asserted during bit 4 of byte 2 of word 10 -> all outputs and shadow entries read 0 in the same cycle. A clean frame afterwards decodes fully.
- Word 0 = 32'h12345678 -> word_data 32'h12345678, with the byte order on the wire 78,56,34,12; latency checked against the Timing formula with and without REGFILE_RX_SYNC_EN.

Source files
------------

// File: rtl/regfile_dump_rx_if.sv
// Host-side bundle for the register-file dump receiver: serial input, word stream,
// status strobes and the shadow register-file read port.
interface regfile_dump_rx_if;
    logic        rx;
    logic        word_valid;
    logic [4:0]  word_index;
    logic [31:0] word_data;
    logic        frame_done;
    logic        frame_error;
    logic        busy;
    logic [4:0]  shadow_read_address;
    logic [31:0] shadow_read_data;

    modport slave (
        input  rx,
        input  shadow_read_address,
        output word_valid,
        output word_index,
        output word_data,
        output frame_done,
        output frame_error,
        output busy,
        output shadow_read_data
    );

    modport master (
        output rx,
        output shadow_read_address,
        input  word_valid,
        input  word_index,
        input  word_data,
        input  frame_done,
        input  frame_error,
        input  busy,
        input  shadow_read_data
    );
endinterface

// File: rtl/regfile_dump_rx.sv
// 8N1 UART receiver that reassembles 128-byte register-file dumps into 32 LE words
// plus a shadow copy. Define REGFILE_RX_SYNC_EN to add a 2-flop rx synchroniser.
module regfile_dump_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 2080
) (
    input  logic               clk12,
    input  logic               rst,
    regfile_dump_rx_if.slave   bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int BIT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W     = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_clk_q, bit_clk_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               rx_prev_q;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [4:0]         word_cnt_q, word_cnt_d;
    logic [23:0]        word_acc_q, word_acc_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               word_valid_q, word_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_error_q, frame_error_d;
    logic [4:0]         word_index_q, word_index_d;
    logic [31:0]        word_data_q, word_data_d;
    logic [31:0]        shadow_q [32];

    logic rx_s;
    logic start_edge, byte_ok, stop_bad, timeout_hit;

`ifdef REGFILE_RX_SYNC_EN
    logic [1:0] sync_q, sync_d;
    assign sync_d = {sync_q[0], bus.rx};
    assign rx_s   = sync_q[1];

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= sync_d;
    end
`else
    assign rx_s = bus.rx;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d       = state_q;
        bit_clk_d     = bit_clk_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        word_cnt_d    = word_cnt_q;
        word_acc_d    = word_acc_q;
        timeout_d     = timeout_q;
        busy_d        = busy_q;
        word_valid_d  = 1'b0;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        word_index_d  = word_index_q;
        word_data_d   = word_data_q;
        start_edge    = 1'b0;
        byte_ok       = 1'b0;
        stop_bad      = 1'b0;
        timeout_hit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    start_edge = 1'b1;
                    state_d    = S_START;
                    bit_clk_d  = '0;
                end
            end
            S_START: begin
                if (bit_clk_q == BIT_W'(HALF_BIT - 1)) begin
                    bit_clk_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    bit_clk_d = bit_clk_q + BIT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_clk_q == BIT_W'(CLKS_PER_BIT - 1)) begin
                    bit_clk_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                end else begin
                    bit_clk_d = bit_clk_q + BIT_W'(1);
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (bit_clk_q == BIT_W'(CLKS_PER_BIT - 1)) begin
                    bit_clk_d = '0;
                    state_d   = S_IDLE;
                    byte_ok   = rx_s;
                    stop_bad  = !rx_s;
                end else begin
                    bit_clk_d = bit_clk_q + BIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog: a start edge in the expiry cycle takes priority.
        if (start_edge || !busy_q) begin
            timeout_d = '0;
        end else if (state_q == S_IDLE) begin
            if (timeout_q == TO_W'(TIMEOUT_CLKS - 1)) timeout_hit = 1'b1;
            else                                      timeout_d   = timeout_q + TO_W'(1);
        end

        if (timeout_hit || stop_bad) begin
            frame_error_d = 1'b1;
            byte_idx_d    = '0;
            word_cnt_d    = '0;
            busy_d        = 1'b0;
            timeout_d     = '0;
        end else if (byte_ok) begin
            byte_idx_d = byte_idx_q + 2'd1;
            busy_d     = 1'b1;
            case (byte_idx_q)
                2'd0: word_acc_d[7:0]   = shift_q;
                2'd1: word_acc_d[15:8]  = shift_q;
                2'd2: word_acc_d[23:16] = shift_q;
                default: begin
                    word_valid_d = 1'b1;
                    word_index_d = word_cnt_q;
                    word_data_d  = {shift_q, word_acc_q};
                    word_cnt_d   = word_cnt_q + 5'd1;
                    if (word_cnt_q == 5'd31) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bit_clk_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            rx_prev_q     <= 1'b1;
            byte_idx_q    <= '0;
            word_cnt_q    <= '0;
            word_acc_q    <= '0;
            timeout_q     <= '0;
            busy_q        <= 1'b0;
            word_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            word_index_q  <= '0;
            word_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            bit_clk_q     <= bit_clk_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_prev_q     <= rx_s;
            byte_idx_q    <= byte_idx_d;
            word_cnt_q    <= word_cnt_d;
            word_acc_q    <= word_acc_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            word_valid_q  <= word_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            word_index_q  <= word_index_d;
            word_data_q   <= word_data_d;
        end
    end

    // Written from the registered strobe, so an entry updates the cycle after word_valid.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            // NOTE: the shadow file must read all-zero straight out of reset, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
        end else if (word_valid_q) begin
            shadow_q[word_index_q] <= word_data_q;
        end
    end

    assign bus.word_valid       = word_valid_q;
    assign bus.word_index       = word_index_q;
    assign bus.word_data        = word_data_q;
    assign bus.frame_done       = frame_done_q;
    assign bus.frame_error      = frame_error_q;
    assign bus.busy             = busy_q;
    assign bus.shadow_read_data = shadow_q[bus.shadow_read_address];

endmodule

// File: tb/tb_regfile_dump_rx.sv
// Directed bench for regfile_dump_rx: reset, byte order/latency, timeout, glitch,
// bad stop bit, full frame and mid-frame reset. Honours REGFILE_RX_SYNC_EN.
module tb_regfile_dump_rx;

    localparam int CPB = 4;
    localparam int TO  = 80;
`ifdef REGFILE_RX_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    localparam int LAT = S + CPB / 2 + 9 * CPB + 1;

    logic clk12 = 1'b0;
    logic rst   = 1'b1;

    regfile_dump_rx_if bus ();

    regfile_dump_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk12 (clk12),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk12 = ~clk12;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;
    int fe_cnt = 0;
    int fd_cnt = 0;
    int clash_cnt = 0;
    int          wv_cyc  [$];
    logic [4:0]  wv_idx  [$];
    logic [31:0] wv_data [$];

    always @(posedge clk12) cyc <= cyc + 1;

    // Strobe recorder; frame_done must ride on word_valid, frame_error never may.
    always @(negedge clk12) begin
        if (!rst) begin
            if (bus.word_valid) begin
                wv_cyc.push_back(cyc);
                wv_idx.push_back(bus.word_index);
                wv_data.push_back(bus.word_data);
            end
            if (bus.frame_error) fe_cnt++;
            if (bus.frame_done)  fd_cnt++;
            if ((bus.frame_error && bus.word_valid) || (bus.frame_done && !bus.word_valid))
                clash_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk12);
            #1;
        end
    endtask

    task automatic clear_log();
        wv_cyc.delete();
        wv_idx.delete();
        wv_data.delete();
        fe_cnt = 0;
        fd_cnt = 0;
        clash_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        last_start = cyc;
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(CPB);
        end
        bus.rx = stop_bit;
        tick(CPB);
        bus.rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic read_shadow(input logic [4:0] addr, input string tag, input logic [31:0] exp);
        bus.shadow_read_address = addr;
        #1;
        check(tag, bus.shadow_read_data, exp);
    endtask

    function automatic logic [31:0] idx_at(input int i);
        return (i < wv_idx.size()) ? 32'(wv_idx[i]) : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] data_at(input int i);
        return (i < wv_data.size()) ? wv_data[i] : 32'hxxxxxxxx;
    endfunction

    initial begin
        bus.rx = 1'b1;
        bus.shadow_read_address = 5'd0;

        // Reset state
        tick(3);
        check("rst_word_valid", bus.word_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_frame_error", bus.frame_error, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_word_index", bus.word_index, 0);
        check("rst_word_data", bus.word_data, 0);
        read_shadow(5'd5, "rst_shadow5", 32'h0);
        tick(1);
        rst = 1'b0;
        tick(5);

        // Byte order and latency: 78,56,34,12 on the wire, then one extra byte and a timeout
        clear_log();
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        tick(4);
        check("order_count", wv_idx.size(), 1);
        check("order_index", idx_at(0), 0);
        check("order_data", data_at(0), 32'h12345678);
        check("order_latency", (wv_cyc.size() > 0) ? wv_cyc[0] - last_start : -1, LAT);
        check("order_busy", bus.busy, 1);
        read_shadow(5'd0, "order_shadow0", 32'h12345678);
        send_byte(8'h55, 1'b1);
        tick(60);
        check("to_early_error", fe_cnt, 0);
        check("to_early_busy", bus.busy, 1);
        tick(40);
        check("to_error_once", fe_cnt, 1);
        check("to_busy_drop", bus.busy, 0);
        check("to_no_partial_word", wv_idx.size(), 1);
        read_shadow(5'd0, "to_shadow0_kept", 32'h12345678);

        // One-cycle glitch on idle line, then a real word
        clear_log();
        bus.rx = 1'b0;
        tick(1);
        bus.rx = 1'b1;
        tick(20);
        check("glitch_no_error", fe_cnt, 0);
        check("glitch_no_word", wv_idx.size(), 0);
        check("glitch_busy", bus.busy, 0);
        send_word(32'hCAFEF00D);
        tick(4);
        check("glitch_next_index", idx_at(0), 0);
        check("glitch_next_data", data_at(0), 32'hCAFEF00D);

        // Bad stop bit in the middle of word 3
        send_word(32'h0BAD0001);
        send_word(32'h0BAD0002);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("stop_busy_before", bus.busy, 1);
        send_byte(8'h33, 1'b0);
        tick(4);
        check("stop_error_once", fe_cnt, 1);
        check("stop_busy_drop", bus.busy, 0);
        check("stop_word_count", wv_idx.size(), 3);
        check("stop_last_index", idx_at(2), 2);
        check("stop_last_data", data_at(2), 32'h0BAD0002);
        tick(10);

        // Full frame after the error: must restart at word 0
        clear_log();
        for (int i = 0; i < 32; i++) send_word(32'hA5000000 | i);
        tick(4);
        check("frame_count", wv_idx.size(), 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("frame_index%0d", i), idx_at(i), i);
            check($sformatf("frame_data%0d", i), data_at(i), 32'hA5000000 | i);
        end
        check("frame_done_once", fd_cnt, 1);
        check("frame_strobe_clash", clash_cnt, 0);
        check("frame_no_error", fe_cnt, 0);
        check("frame_busy_end", bus.busy, 0);
        read_shadow(5'd7, "frame_shadow7", 32'hA5000007);

        // Reset during bit 4 of byte 2 of word 10
        clear_log();
        for (int i = 0; i < 10; i++) send_word(32'hC3000000 | i);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1);
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b0;
            tick(CPB);
        end
        bus.rx = 1'b0;
        tick(2);
        check("mid_busy", bus.busy, 1);
        read_shadow(5'd3, "mid_shadow3", 32'hC3000003);
        rst = 1'b1;
        #1;
        check("arst_word_valid", bus.word_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_word_index", bus.word_index, 0);
        check("arst_word_data", bus.word_data, 0);
        check("arst_frame_error", bus.frame_error, 0);
        for (int i = 0; i < 32; i++) read_shadow(5'(i), $sformatf("arst_shadow%0d", i), 32'h0);
        bus.rx = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(10);

        clear_log();
        for (int i = 0; i < 32; i++) send_word(32'h5A000000 | (i << 8) | i);
        tick(4);
        check("post_count", wv_idx.size(), 32);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("post_index%0d", i), idx_at(i), i);
            check($sformatf("post_data%0d", i), data_at(i), 32'h5A000000 | (i << 8) | i);
        end
        check("post_done_once", fd_cnt, 1);
        check("post_no_error", fe_cnt, 0);
        read_shadow(5'd31, "post_shadow31", 32'h5A001F1F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
